// File: rtl/rrv64_l1l2_victim_buf.sv
// Victim write-back FIFO between the L1 eviction path and the L2 request port.
// Optional coalescing of non-head duplicates: define RRV64_VICTIM_BUF_COALESCE_EN.
module rrv64_l1l2_victim_buf #(
  parameter int unsigned LADDR_W = 50,
  parameter int unsigned LINE_W  = 512,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_exclusive_i,
  input  logic               evict_vld_i,
  output logic               evict_rdy_o,
  input  logic [LADDR_W-1:0] evict_addr_i,
  input  logic               evict_dirty_i,
  input  logic [LINE_W-1:0]  evict_data_i,
  output logic               l2_wb_vld_o,
  input  logic               l2_wb_rdy_i,
  output logic [LADDR_W-1:0] l2_wb_addr_o,
  output logic [LINE_W-1:0]  l2_wb_data_o,
  output logic               l2_wb_dirty_o,
  input  logic [LADDR_W-1:0] lkup_addr_i,
  output logic               lkup_hit_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0]   r_vld;
  logic [DEPTH-1:0]   r_dirty;
  logic [LADDR_W-1:0] r_addr [DEPTH];
  logic [LINE_W-1:0]  r_data [DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_cnt;

  logic             w_head_match;
  logic             w_coal_hit;
  logic [DEPTH-1:0] w_coal_sel;
  logic             w_acc;
  logic             w_keep;
  logic             w_enq;
  logic             w_coal;
  logic             w_deq;

  // Head entry drives the L2 port straight from its registers
  assign l2_wb_vld_o   = r_vld[r_rptr];
  assign l2_wb_addr_o  = r_addr[r_rptr];
  assign l2_wb_data_o  = r_data[r_rptr];
  assign l2_wb_dirty_o = r_dirty[r_rptr];

  assign count_o = r_cnt;
  assign empty_o = (r_cnt == '0);

  // Matching the presented head would let it change under L2, so stall instead
  assign w_head_match = l2_wb_vld_o && (r_addr[r_rptr] == evict_addr_i);

  always_comb begin
    w_coal_sel = '0;
`ifdef RRV64_VICTIM_BUF_COALESCE_EN
    for (int i = 0; i < DEPTH; i++) begin
      w_coal_sel[i] = r_vld[i] && (PTR_W'(i) != r_rptr) && (r_addr[i] == evict_addr_i);
    end
`endif
  end

  assign w_coal_hit  = |w_coal_sel;
  assign evict_rdy_o = !rst && ((r_cnt < CNT_W'(DEPTH)) || w_coal_hit) && !w_head_match;

  assign w_acc  = evict_vld_i && evict_rdy_o;
  assign w_keep = evict_dirty_i || cfg_exclusive_i;
  assign w_coal = w_acc && w_keep && w_coal_hit;
  assign w_enq  = w_acc && w_keep && !w_coal_hit;
  assign w_deq  = l2_wb_vld_o && l2_wb_rdy_i;

  always_comb begin
    lkup_hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      lkup_hit_o = lkup_hit_o | (r_vld[i] && (r_addr[i] == lkup_addr_i));
    end
  end

  // Entry storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld   <= '0;
      r_dirty <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_deq) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + PTR_W'(1);
      end
      if (w_enq) begin
        r_vld[r_wptr]   <= 1'b1;
        r_addr[r_wptr]  <= evict_addr_i;
        r_dirty[r_wptr] <= evict_dirty_i;
        r_data[r_wptr]  <= evict_data_i;
        r_wptr          <= r_wptr + PTR_W'(1);
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (w_coal && w_coal_sel[i]) begin
          r_data[i]  <= evict_data_i;
          r_dirty[i] <= r_dirty[i] | evict_dirty_i;
        end
      end
      if (w_enq && !w_deq) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (!w_enq && w_deq) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rrv64_l1l2_victim_buf.sv
// Randomized and directed bench for rrv64_l1l2_victim_buf against a queue-based model.
module tb_rrv64_l1l2_victim_buf;

  localparam int unsigned LADDR_W = 50;
  localparam int unsigned LINE_W  = 512;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CNT_W   = 3;

  logic               clk;
  logic               rst;
  logic               cfg_exclusive_i;
  logic               evict_vld_i;
  logic               evict_rdy_o;
  logic [LADDR_W-1:0] evict_addr_i;
  logic               evict_dirty_i;
  logic [LINE_W-1:0]  evict_data_i;
  logic               l2_wb_vld_o;
  logic               l2_wb_rdy_i;
  logic [LADDR_W-1:0] l2_wb_addr_o;
  logic [LINE_W-1:0]  l2_wb_data_o;
  logic               l2_wb_dirty_o;
  logic [LADDR_W-1:0] lkup_addr_i;
  logic               lkup_hit_o;
  logic [CNT_W-1:0]   count_o;
  logic               empty_o;

  rrv64_l1l2_victim_buf #(
    .LADDR_W(LADDR_W), .LINE_W(LINE_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .rst(rst), .cfg_exclusive_i(cfg_exclusive_i),
    .evict_vld_i(evict_vld_i), .evict_rdy_o(evict_rdy_o),
    .evict_addr_i(evict_addr_i), .evict_dirty_i(evict_dirty_i),
    .evict_data_i(evict_data_i), .l2_wb_vld_o(l2_wb_vld_o),
    .l2_wb_rdy_i(l2_wb_rdy_i), .l2_wb_addr_o(l2_wb_addr_o),
    .l2_wb_data_o(l2_wb_data_o), .l2_wb_dirty_o(l2_wb_dirty_o),
    .lkup_addr_i(lkup_addr_i), .lkup_hit_o(lkup_hit_o),
    .count_o(count_o), .empty_o(empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LADDR_W-1:0] addr;
    logic               dirty;
    logic [LINE_W-1:0]  data;
  } ent_t;

  ent_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic post_rst;

  task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] d;
    for (int i = 0; i < LINE_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // One cycle: drive at negedge, check against the model, then advance the model past the edge
  task automatic step(input logic r, input logic ex, input logic v, input logic [LADDR_W-1:0] a,
                      input logic d, input logic [LINE_W-1:0] dat, input logic l2r,
                      input logic [LADDR_W-1:0] lk);
    logic exp_rdy;
    logic exp_hit;
    int   coal_idx;
    ent_t e;
    @(negedge clk);
    rst = r; cfg_exclusive_i = ex; evict_vld_i = v; evict_addr_i = a;
    evict_dirty_i = d; evict_data_i = dat; l2_wb_rdy_i = l2r; lkup_addr_i = lk;
    #1;
    coal_idx = -1;
`ifdef RRV64_VICTIM_BUF_COALESCE_EN
    for (int i = 1; i < q.size(); i++) if (q[i].addr == a) coal_idx = i;
`endif
    exp_rdy = !r && ((q.size() < DEPTH) || (coal_idx > 0)) && !(q.size() > 0 && q[0].addr == a);
    exp_hit = 1'b0;
    foreach (q[i]) if (q[i].addr == lk) exp_hit = 1'b1;
    chk("evict_rdy", LINE_W'(evict_rdy_o), LINE_W'(exp_rdy));
    chk("count", LINE_W'(count_o), LINE_W'(q.size()));
    chk("empty", LINE_W'(empty_o), LINE_W'(q.size() == 0));
    chk("l2_vld", LINE_W'(l2_wb_vld_o), LINE_W'(q.size() > 0));
    chk("lkup_hit", LINE_W'(lkup_hit_o), LINE_W'(exp_hit));
    if (q.size() > 0) begin
      chk("l2_addr", LINE_W'(l2_wb_addr_o), LINE_W'(q[0].addr));
      chk("l2_dirty", LINE_W'(l2_wb_dirty_o), LINE_W'(q[0].dirty));
      chk("l2_data", l2_wb_data_o, q[0].data);
    end else if (post_rst) begin
      chk("rst_addr", LINE_W'(l2_wb_addr_o), '0);
      chk("rst_dirty", LINE_W'(l2_wb_dirty_o), '0);
      chk("rst_data", l2_wb_data_o, '0);
    end
    post_rst = r;
    if (r) begin
      q.delete();
    end else begin
      logic do_deq;
      do_deq = (q.size() > 0) && l2r;
      if (v && exp_rdy && (d || ex)) begin
        if (coal_idx > 0) begin
          q[coal_idx].data  = dat;
          q[coal_idx].dirty = q[coal_idx].dirty | d;
        end else begin
          e.addr = a; e.dirty = d; e.data = dat;
          q.push_back(e);
        end
      end
      if (do_deq) void'(q.pop_front());
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic l2r, input logic [LADDR_W-1:0] lk);
    step(1'b0, 1'b0, 1'b0, LADDR_W'(0), 1'b0, '0, l2r, lk);
  endtask

  localparam logic [LADDR_W-1:0] A30 = LADDR_W'('h30);

  initial begin
    logic [LINE_W-1:0] d0;
    logic [LINE_W-1:0] d1;
    logic [LINE_W-1:0] a5;
    rst = 1'b1; cfg_exclusive_i = 1'b0; evict_vld_i = 1'b0; evict_addr_i = '0;
    evict_dirty_i = 1'b0; evict_data_i = '0; l2_wb_rdy_i = 1'b0; lkup_addr_i = '0;
    post_rst = 1'b1;
    repeat (3) @(posedge clk);

    // Reset values
    step(1'b1, 1'b0, 1'b1, LADDR_W'('h100), 1'b1, '0, 1'b0, A30);
    idle(1'b0, A30);

    // Inclusive clean drop
    step(1'b0, 1'b0, 1'b1, LADDR_W'('h100), 1'b0, rand_line(), 1'b0, A30);
    settle();
    chk("incl_drop_count", LINE_W'(count_o), '0);
    chk("incl_drop_vld", LINE_W'(l2_wb_vld_o), '0);
    idle(1'b0, A30);

    // Exclusive clean forward
    a5 = {(LINE_W/8){8'hA5}};
    step(1'b0, 1'b1, 1'b1, LADDR_W'('h100), 1'b0, a5, 1'b0, A30);
    settle();
    chk("excl_fwd_vld", LINE_W'(l2_wb_vld_o), LINE_W'(1));
    chk("excl_fwd_data", l2_wb_data_o, a5);
    idle(1'b1, A30);
    idle(1'b0, A30);

    // Full and backpressure, FIFO drain order
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 1'b1, LADDR_W'(i), 1'b1, rand_line(), 1'b0, A30);
    step(1'b0, 1'b0, 1'b0, LADDR_W'(5), 1'b0, '0, 1'b0, A30);
    settle();
    chk("full_count", LINE_W'(count_o), LINE_W'(4));
    chk("full_rdy", LINE_W'(evict_rdy_o), '0);
    step(1'b0, 1'b0, 1'b0, LADDR_W'(5), 1'b0, '0, 1'b1, A30);
    settle();
    chk("pulse_count", LINE_W'(count_o), LINE_W'(3));
    chk("pulse_rdy", LINE_W'(evict_rdy_o), LINE_W'(1));
    chk("pulse_head", LINE_W'(l2_wb_addr_o), LINE_W'(2));
    repeat (4) idle(1'b1, A30);

    // Coalesce / duplicate handling and head-match stall
    d0 = rand_line();
    d1 = rand_line();
    step(1'b0, 1'b1, 1'b1, LADDR_W'('h10), 1'b1, rand_line(), 1'b0, A30);
    step(1'b0, 1'b1, 1'b1, LADDR_W'('h20), 1'b1, d0, 1'b0, A30);
    step(1'b0, 1'b1, 1'b1, LADDR_W'('h20), 1'b0, d1, 1'b0, A30);
    step(1'b0, 1'b1, 1'b1, LADDR_W'('h10), 1'b1, rand_line(), 1'b0, A30);
    settle();
`ifdef RRV64_VICTIM_BUF_COALESCE_EN
    chk("coal_count", LINE_W'(count_o), LINE_W'(2));
`else
    chk("coal_count", LINE_W'(count_o), LINE_W'(3));
`endif
    chk("coal_stall_rdy", LINE_W'(evict_rdy_o), '0);
    repeat (4) idle(1'b1, A30);

    // Lookup hit then clear after drain
    step(1'b0, 1'b0, 1'b1, LADDR_W'('h20), 1'b1, rand_line(), 1'b0, LADDR_W'('h20));
    idle(1'b0, LADDR_W'('h20));
    idle(1'b1, LADDR_W'('h20));
    settle();
    chk("lkup_after_drain", LINE_W'(lkup_hit_o), '0);
    idle(1'b0, A30);

    // Reset mid-operation
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b0, 1'b1, LADDR_W'(i), 1'b1, rand_line(), 1'b0, LADDR_W'(1));
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, LADDR_W'(1));
    idle(1'b0, LADDR_W'(1));
    settle();
    chk("post_rst_rdy", LINE_W'(evict_rdy_o), LINE_W'(1));
    chk("post_rst_count", LINE_W'(count_o), '0);

    // Randomized traffic over a small address range to provoke matches
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0), 1'($urandom), ($urandom_range(0, 3) != 0),
           LADDR_W'($urandom_range(0, 7)), 1'($urandom), rand_line(),
           ($urandom_range(0, 2) == 0), LADDR_W'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
